spi_shifter: RTL and testbench

- Serial datapath stage directly downstream of the SPI master/slave controller.
- Holds the SPI Data Register (SPDR) and an 8-bit shift register.
- Shifts one byte per transfer under the controller's Shifter_en / SPDR_rd_en / SPDR_wr_en strobes, paced by baud ticks.
- Returns the 3-bit bit counter that the controller uses to detect end of byte.

---
 rtl/spi_shifter.sv | 155 +++++++++++++++
 tb/tb_spi_shifter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_shifter
// Purpose  : SPDR plus 8-bit SPI mode-0 shift register driven by the SPI
//            controller strobes. Define SPI_RX_BUFFER_EN to add a separate
//            receive buffer with overrun detection.
// Revision : 1.0  initial release
// ============================================================================
module spi_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic              MSTR,
  input  logic              DORD,
  input  logic              Shifter_en,
  input  logic              SPDR_rd_en,
  input  logic              SPDR_wr_en,
  input  logic              spdr_we,
  input  logic [DATA_W-1:0] spdr_wdata,
  input  logic              spdr_rd,
  input  logic              wcol_clr,
  input  logic              miso_i,
  input  logic              mosi_i,
  output logic              serial_o,
  output logic              serial_oe,
  output logic [2:0]        counter,
  output logic              byte_done,
  output logic [DATA_W-1:0] spdr_rdata,
  output logic              WCOL,
  output logic              OVR
);

  localparam logic [2:0] LAST_BIT = 3'd7;

  logic [DATA_W-1:0] spdr;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        cnt;
  logic              phase;
  logic              rx_bit;
  logic              done_r;
  logic              wcol_r;
  logic              sin;
  logic              tick_en;
  logic              shift_now;
  logic              collide;

  assign sin       = MSTR ? miso_i : mosi_i;
  assign tick_en   = Shifter_en & baud_tick;
  assign shift_now = tick_en & phase;

  assign serial_o  = DORD ? shreg[0] : shreg[DATA_W-1];
  assign serial_oe = Shifter_en;
  assign counter   = cnt;
  assign byte_done = done_r;
  assign WCOL      = wcol_r;

  // Sample on the first tick of a bit, shift on the second; dropping
  // Shifter_en returns the bit sequencer to the start of a byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      cnt    <= '0;
      phase  <= 1'b0;
      rx_bit <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= shift_now & (cnt == LAST_BIT);
      if (Shifter_en) begin
        if (tick_en && !phase) begin
          rx_bit <= sin;
          phase  <= 1'b1;
        end else if (shift_now) begin
          shreg  <= DORD ? {rx_bit, shreg[DATA_W-1:1]} : {shreg[DATA_W-2:0], rx_bit};
          cnt    <= cnt + 3'd1;
          phase  <= 1'b0;
        end
      end else begin
        cnt   <= '0;
        phase <= 1'b0;
        if (SPDR_rd_en) begin
          shreg <= spdr;
        end
      end
    end
  end

`ifdef SPI_RX_BUFFER_EN
  logic [DATA_W-1:0] rx_buf;
  logic              rx_full;
  logic              ovr_r;
  logic              overrun;

  // A read in the same cycle frees the buffer, so that commit is accepted.
  assign overrun    = SPDR_wr_en & rx_full & ~spdr_rd;
  assign collide    = spdr_we & Shifter_en;
  assign spdr_rdata = rx_buf;
  assign OVR        = ovr_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      spdr    <= '0;
      rx_buf  <= '0;
      rx_full <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      if (spdr_we && !Shifter_en) begin
        spdr <= spdr_wdata;
      end
      if (SPDR_wr_en && !overrun) begin
        rx_buf  <= shreg;
        rx_full <= 1'b1;
      end else if (spdr_rd) begin
        rx_full <= 1'b0;
      end
      if (spdr_rd) begin
        ovr_r <= 1'b0;
      end else if (overrun) begin
        ovr_r <= 1'b1;
      end
    end
  end
`else
  logic unused_spdr_rd;

  assign unused_spdr_rd = spdr_rd;
  assign collide        = spdr_we & (Shifter_en | SPDR_wr_en);
  assign spdr_rdata     = spdr;
  assign OVR            = 1'b0;

  // The received byte overwrites SPDR ahead of any processor write.
  always_ff @(posedge clk) begin
    if (rst) begin
      spdr <= '0;
    end else if (SPDR_wr_en) begin
      spdr <= shreg;
    end else if (spdr_we && !Shifter_en) begin
      spdr <= spdr_wdata;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wcol_r <= 1'b0;
    end else if (collide) begin
      wcol_r <= 1'b1;
    end else if (wcol_clr) begin
      wcol_r <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_shifter.sv
`default_nettype none
// Testbench for spi_shifter: byte-level reference model, per-cycle compare,
// directed scenarios with literal expectations and randomized operations.
module tb_spi_shifter;

  logic       clk = 1'b0;
  logic       rst, baud_tick, MSTR, DORD, Shifter_en, SPDR_rd_en, SPDR_wr_en;
  logic       spdr_we, spdr_rd, wcol_clr, miso_i, mosi_i;
  logic [7:0] spdr_wdata;
  logic       serial_o, serial_oe, byte_done, WCOL, OVR;
  logic [2:0] counter;
  logic [7:0] spdr_rdata;

  spi_shifter #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .MSTR(MSTR), .DORD(DORD),
    .Shifter_en(Shifter_en), .SPDR_rd_en(SPDR_rd_en), .SPDR_wr_en(SPDR_wr_en),
    .spdr_we(spdr_we), .spdr_wdata(spdr_wdata), .spdr_rd(spdr_rd), .wcol_clr(wcol_clr),
    .miso_i(miso_i), .mosi_i(mosi_i), .serial_o(serial_o), .serial_oe(serial_oe),
    .counter(counter), .byte_done(byte_done), .spdr_rdata(spdr_rdata),
    .WCOL(WCOL), .OVR(OVR)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: whole bytes plus the number of baud ticks into the transfer.
  logic [7:0] m_spdr = 0, m_sh = 0, m_base = 0, m_rx = 0, m_rxbuf = 0;
  logic       m_wcol = 0, m_ovr = 0, m_full = 0, m_bd = 0, m_valid = 0;
  int         m_t = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Shift register contents after k completed bits: the unsent part of the
  // transmitted byte joined with the first k received bits.
  function automatic logic [7:0] shape(logic [7:0] tx, logic [7:0] rx, int k, logic lsb);
    logic [15:0] a, b;
    if (!lsb) begin
      a = {8'h00, tx} << k;
      b = {8'h00, rx} >> (8 - k);
    end else begin
      a = {8'h00, tx} >> k;
      b = {8'h00, rx} << (8 - k);
    end
    return a[7:0] | b[7:0];
  endfunction

  function automatic logic [7:0] exp_rdata();
`ifdef SPI_RX_BUFFER_EN
    return m_rxbuf;
`else
    return m_spdr;
`endif
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("serial_o",   serial_o,   DORD ? m_sh[0] : m_sh[7]);
      chk("serial_oe",  serial_oe,  Shifter_en);
      chk("counter",    counter,    (m_t / 2) % 8);
      chk("byte_done",  byte_done,  m_bd);
      chk("spdr_rdata", spdr_rdata, exp_rdata());
      chk("WCOL",       WCOL,       m_wcol);
      chk("OVR",        OVR,        m_ovr);
    end
  end

  // One clock: the model consumes the inputs the DUT sees on this edge.
  task automatic step();
    logic [7:0] sh0, sp0;
    logic       full0;
    @(posedge clk);
    sh0 = m_sh; sp0 = m_spdr; full0 = m_full;
    m_valid = 1;
    if (rst) begin
      m_spdr = 0; m_sh = 0; m_base = 0; m_t = 0; m_bd = 0;
      m_wcol = 0; m_ovr = 0; m_rxbuf = 0; m_full = 0;
    end else begin
      m_bd = 0;
      if (Shifter_en) begin
        if (baud_tick) begin
          m_t++;
          if (m_t % 2 == 0) begin
            m_sh = shape(m_base, m_rx, m_t / 2, DORD);
            if (m_t % 16 == 0) m_bd = 1;
          end
        end
      end else begin
        m_t = 0;
        if (SPDR_rd_en) m_sh = sp0;
        m_base = m_sh;
      end
`ifdef SPI_RX_BUFFER_EN
      if (spdr_we && !Shifter_en) m_spdr = spdr_wdata;
      if (spdr_we && Shifter_en) m_wcol = 1;
      else if (wcol_clr) m_wcol = 0;
      if (spdr_rd) begin m_full = 0; m_ovr = 0; end
      if (SPDR_wr_en) begin
        if (full0 && !spdr_rd) m_ovr = 1;
        else begin m_rxbuf = sh0; m_full = 1; end
      end
`else
      if (SPDR_wr_en) m_spdr = sh0;
      else if (spdr_we && !Shifter_en) m_spdr = spdr_wdata;
      if (spdr_we && (Shifter_en || SPDR_wr_en)) m_wcol = 1;
      else if (wcol_clr) m_wcol = 0;
`endif
    end
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    spdr_we = 1; spdr_wdata = d; step(); spdr_we = 0;
  endtask

  task automatic load(input int n);
    SPDR_rd_en = 1; repeat (n) step(); SPDR_rd_en = 0;
  endtask

  task automatic commit();
    SPDR_wr_en = 1; step(); SPDR_wr_en = 0;
  endtask

  task automatic rd();
    spdr_rd = 1; step(); spdr_rd = 0;
  endtask

  task automatic stop();
    baud_tick = 0; Shifter_en = 0; step();
  endtask

  // Runs `ticks` baud ticks with Shifter_en held; leaves Shifter_en asserted.
  task automatic transfer(input bit mstr, input bit dord, input logic [7:0] rx,
                          input int ticks, input int gap_max, input bit noise,
                          output logic [7:0] seq, output int bd_cnt);
    int guard;
    MSTR = mstr; DORD = dord; m_rx = rx; Shifter_en = 1;
    seq = 0; bd_cnt = 0; guard = 0;
    while (m_t < ticks && guard < 1000) begin
      int   idx;
      logic b;
      idx = (m_t / 2 > 7) ? 7 : m_t / 2;
      b   = dord ? rx[idx] : rx[7 - idx];
      if (mstr) begin miso_i = b; mosi_i = 1'($urandom); end
      else      begin mosi_i = b; miso_i = 1'($urandom); end
      if (m_t % 2 == 0 && m_t < 16) seq[7 - m_t / 2] = serial_o;
      baud_tick  = ($urandom_range(0, gap_max) == 0);
      spdr_we    = noise && ($urandom_range(0, 9) == 0);
      spdr_wdata = 8'($urandom);
      SPDR_rd_en = noise && ($urandom_range(0, 7) == 0);
      step();
      spdr_we = 0; SPDR_rd_en = 0;
      bd_cnt += int'(byte_done);
      guard++;
    end
    if (m_t < ticks) chk("xfer_timeout", m_t, ticks);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual running required finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq;
    int         bd;
    rst = 1; baud_tick = 0; MSTR = 1; DORD = 0; Shifter_en = 0; SPDR_rd_en = 0;
    SPDR_wr_en = 0; spdr_we = 0; spdr_wdata = 0; spdr_rd = 0; wcol_clr = 0;
    miso_i = 0; mosi_i = 0;
    step(); step();
    chk("rst_rdata", spdr_rdata, 8'h00);
    chk("rst_counter", counter, 3'd0);
    chk("rst_wcol", WCOL, 1'b0);
    chk("rst_ovr", OVR, 1'b0);
    chk("rst_serial", serial_o, 1'b0);
    rst = 0;

    wr(8'hA5); load(2);
    transfer(1, 0, 8'h3C, 16, 1, 0, seq, bd); stop();
    chk("master_seq", seq, 8'hA5);
    chk("master_bd", bd, 1);
    commit();
    chk("master_rdata", spdr_rdata, 8'h3C);
    rd();

    wr(8'h81); load(2);
    transfer(0, 1, 8'h0F, 16, 2, 0, seq, bd); stop();
    chk("slave_seq", seq, 8'h81);
    commit();
    chk("slave_rdata", spdr_rdata, 8'h0F);
    rd();

    Shifter_en = 1; spdr_we = 1; spdr_wdata = 8'h55; step();
    Shifter_en = 0; spdr_we = 0;
    chk("coll_wcol", WCOL, 1'b1);
    chk("coll_rdata", spdr_rdata, 8'h0F);
    wcol_clr = 1; step(); wcol_clr = 0;
    chk("wcol_clr", WCOL, 1'b0);

    wr(8'hC3); load(2);
    transfer(1, 0, 8'h96, 6, 0, 0, seq, bd);
    chk("abort_cnt3", counter, 3'd3);
    stop();
    chk("abort_cnt0", counter, 3'd0);
    load(1);
    transfer(1, 0, 8'h5A, 16, 1, 0, seq, bd); stop();
    chk("restart_seq", seq, 8'hC3);
    chk("restart_bd", bd, 1);

`ifdef SPI_RX_BUFFER_EN
    rd();
    wr(8'h11); load(2); commit();
    wr(8'h22); load(2); commit();
    chk("ovr_rxbuf", spdr_rdata, 8'h11);
    chk("ovr_set", OVR, 1'b1);
    rd();
    chk("ovr_clr", OVR, 1'b0);
`endif

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          spdr_we = 1; spdr_wdata = 8'($urandom);
          SPDR_wr_en = ($urandom_range(0, 3) == 0);
          step(); spdr_we = 0; SPDR_wr_en = 0;
        end
        1: load($urandom_range(1, 3));
        2: begin
          transfer(1'($urandom), 1'($urandom), 8'($urandom),
                   ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 16,
                   $urandom_range(0, 3), 1, seq, bd);
          stop();
        end
        3: begin
          spdr_rd = ($urandom_range(0, 1) == 0);
          commit(); spdr_rd = 0;
        end
        default: begin
          repeat ($urandom_range(1, 4)) begin
            baud_tick = 1'($urandom);
            wcol_clr  = ($urandom_range(0, 3) == 0);
            spdr_rd   = ($urandom_range(0, 3) == 0);
            step();
          end
          baud_tick = 0; wcol_clr = 0; spdr_rd = 0;
        end
      endcase
    end
    step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
